regfile_wport_arbiter: RTL and testbench



---
 rtl/regfile_wport_arbiter_pkg.sv | 21 ++
 rtl/regfile_wport_arbiter_rf_wq_fifo.sv | 93 +++++++++
 rtl/regfile_wport_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wport_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, constants and the queued-write entry type for the regfile write-port arbiter.
package regfile_wport_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int RF_WADDR_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic                  kill;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wq_entry_t;

    function automatic logic [RF_WADDR_W-1:0] zext_addr(input logic [REG_ADDR_W-1:0] a);
        return RF_WADDR_W'(a);
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_rf_wq_fifo.sv
// Circular buffer of pending MDU register writes with WAW kill-by-address and
// youngest-live-match lookup on two hazard ports.
module rf_wq_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  full,
    output logic                  head_valid,
    output logic                  head_kill,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic                  hit1,
    output logic [DATA_W-1:0]     data1,
    output logic                  hit2,
    output logic [DATA_W-1:0]     data2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    wq_entry_t        head;

    // Push never lands on the popped slot: push needs !full, pop needs !empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem[i].valid && mem[i].addr == kill_addr) begin
                    mem[i].kill <= 1'b1;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, kill: 1'b0, addr: push_addr, data: push_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = head.valid;
    assign head_kill  = head.kill;
    assign head_addr  = head.addr;
    assign head_data  = head.data;
    assign full       = (cnt == CNT_W'(DEPTH));

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        wq_entry_t e;
        e     = '0;
        hit1  = 1'b0;
        data1 = '0;
        hit2  = 1'b0;
        data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            e = mem[rd_ptr + PTR_W'(k)];
            if (e.valid && !e.kill && chk_addr1 != ZERO_REG && e.addr == chk_addr1) begin
                hit1  = 1'b1;
                data1 = e.data;
            end
            if (e.valid && !e.kill && chk_addr2 != ZERO_REG && e.addr == chk_addr2) begin
                hit2  = 1'b1;
                data2 = e.data;
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single regfile write port shared by WB (absolute priority) and queued MDU results,
// with pending-write lookup and a starvation hold request.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0]     wb_wdata,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_waddr,
    input  logic [DATA_W-1:0]     md_wdata,
    output logic                  rf_we,
    output logic [RF_WADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  pend_hit1,
    output logic                  pend_hit2,
    output logic [DATA_W-1:0]     pend_data1,
    output logic [DATA_W-1:0]     pend_data2,
    output logic                  wb_hold
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                  wb_live;
    logic                  q_full;
    logic                  q_push;
    logic                  q_pop;
    logic                  head_valid;
    logic                  head_kill;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic                  hit1;
    logic                  hit2;
    logic [DATA_W-1:0]     data1;
    logic [DATA_W-1:0]     data2;
    logic [STARVE_W-1:0]   starve_cnt;

    assign wb_live = wb_we && (wb_waddr != ZERO_REG);
    assign q_pop   = !rst && !wb_live && head_valid;
    // Results to $0 complete the handshake but never occupy an entry.
    assign q_push  = !rst && md_valid && !q_full && (md_waddr != ZERO_REG);

    rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_addr  (md_waddr),
        .push_data  (md_wdata),
        .pop        (q_pop),
        .kill_en    (wb_live && !rst),
        .kill_addr  (wb_waddr),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .full       (q_full),
        .head_valid (head_valid),
        .head_kill  (head_kill),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .hit1       (hit1),
        .data1      (data1),
        .hit2       (hit2),
        .data2      (data2)
    );

    always_ff @(posedge clk) begin
        if (rst || !head_valid || q_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // A killed head still pops, but its write is suppressed.
    always_comb begin
        md_ready   = 1'b1;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        pend_hit1  = 1'b0;
        pend_hit2  = 1'b0;
        pend_data1 = '0;
        pend_data2 = '0;
        wb_hold    = 1'b0;
        if (!rst) begin
            md_ready   = !q_full;
            pend_hit1  = hit1;
            pend_hit2  = hit2;
            pend_data1 = data1;
            pend_data2 = data2;
            wb_hold    = (starve_cnt == STARVE_W'(STARVE_LIMIT));
            if (wb_live) begin
                rf_we    = 1'b1;
                rf_waddr = zext_addr(wb_waddr);
                rf_wdata = wb_wdata;
            end else if (head_valid && !head_kill) begin
                rf_we    = 1'b1;
                rf_waddr = zext_addr(head_addr);
                rf_wdata = head_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed and randomized checks of the regfile write-port arbiter against a queue model.
module tb_regfile_wport_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        rf_we;
    logic [31:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic [31:0] pend_data1;
    logic [31:0] pend_data2;
    logic        wb_hold;

    regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_waddr   (md_waddr),
        .md_wdata   (md_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .pend_hit1  (pend_hit1),
        .pend_hit2  (pend_hit2),
        .pend_data1 (pend_data1),
        .pend_data2 (pend_data2),
        .wb_hold    (wb_hold)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          killed;
    } ent_t;

    ent_t q[$];
    int   starve;
    bit   last_acc;
    int   tests;
    int   fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output bit h, output logic [31:0] d);
        h = 0;
        d = '0;
        if (a != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!q[i].killed && q[i].addr == a) begin
                    h = 1;
                    d = q[i].data;
                    break;
                end
            end
        end
    endfunction

    // Compare all outputs against the model for the current inputs, then advance one clock.
    task automatic step();
        bit          wl, nonempty, pop_m, acc;
        bit          e_we, e_ready, e_h1, e_h2, e_hold;
        logic [31:0] e_addr, e_data, e_d1, e_d2;
        #2;
        wl      = wb_we && wb_waddr != 0;
        e_we    = 0;
        e_addr  = '0;
        e_data  = '0;
        e_ready = 1;
        e_h1    = 0;
        e_h2    = 0;
        e_d1    = '0;
        e_d2    = '0;
        e_hold  = 0;
        if (!rst) begin
            if (wl) begin
                e_we   = 1;
                e_addr = {27'b0, wb_waddr};
                e_data = wb_wdata;
            end else if (q.size() > 0 && !q[0].killed) begin
                e_we   = 1;
                e_addr = {27'b0, q[0].addr};
                e_data = q[0].data;
            end
            e_ready = q.size() < DEPTH;
            lookup(chk_addr1, e_h1, e_d1);
            lookup(chk_addr2, e_h2, e_d2);
            e_hold = (starve == LIMIT);
        end
        chk("rf_we",      32'(rf_we),     32'(e_we));
        chk("rf_waddr",   rf_waddr,       e_addr);
        chk("rf_wdata",   rf_wdata,       e_data);
        chk("md_ready",   32'(md_ready),  32'(e_ready));
        chk("pend_hit1",  32'(pend_hit1), 32'(e_h1));
        chk("pend_data1", pend_data1,     e_d1);
        chk("pend_hit2",  32'(pend_hit2), 32'(e_h2));
        chk("pend_data2", pend_data2,     e_d2);
        chk("wb_hold",    32'(wb_hold),   32'(e_hold));
        @(posedge clk);
        if (rst) begin
            q.delete();
            starve   = 0;
            last_acc = md_valid;
        end else begin
            nonempty = q.size() > 0;
            pop_m    = !wl && nonempty;
            acc      = md_valid && (q.size() < DEPTH);
            last_acc = acc;
            if (pop_m) void'(q.pop_front());
            if (wl) begin
                foreach (q[i]) if (q[i].addr == wb_waddr) q[i].killed = 1;
            end
            if (acc && md_waddr != 0) q.push_back('{addr: md_waddr, data: md_wdata, killed: 0});
            if (nonempty && !pop_m) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else starve = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        wb_we    = 0;
        md_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int k;
        int busy_pct;
        tests     = 0;
        fails     = 0;
        starve    = 0;
        last_acc  = 0;
        rst       = 1;
        wb_we     = 0;
        wb_waddr  = 0;
        wb_wdata  = 0;
        md_valid  = 1;
        md_waddr  = 5'd9;
        md_wdata  = 32'hDEAD;
        chk_addr1 = 5'd9;
        chk_addr2 = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with an MDU result offered: it must be dropped.
        step();
        rst      = 0;
        md_valid = 0;
        #1;
        chk("idle_md_ready", 32'(md_ready), 32'd1);
        chk("idle_rf_we", 32'(rf_we), 32'd0);
        chk("dropped_in_rst", 32'(pend_hit1), 32'd0);
        idle(2);

        // Single MDU push drains on the next cycle.
        md_valid = 1;
        md_waddr = 5'd5;
        md_wdata = 32'h1234;
        step();
        md_valid = 0;
        #1;
        chk("drain5_we", 32'(rf_we), 32'd1);
        chk("drain5_addr", rf_waddr, 32'd5);
        chk("drain5_data", rf_wdata, 32'h1234);
        step();
        chk("after5_we", 32'(rf_we), 32'd0);
        idle(1);

        // WB saturates the port while the MDU fills the FIFO.
        k        = 0;
        last_acc = 0;
        wb_we    = 1;
        wb_waddr = 5'd1;
        for (int i = 0; i < 12; i++) begin
            if (last_acc) k++;
            md_valid = (k < 5);
            md_waddr = 5'(10 + k);
            md_wdata = 32'(100 + k);
            wb_wdata = 32'(i);
            step();
            if (i == 3) chk("full_md_ready", 32'(md_ready), 32'd0);
        end
        chk("starve_hold", 32'(wb_hold), 32'd1);
        chk("held_md_ready", 32'(md_ready), 32'd0);
        wb_we = 0;
        #1;
        chk("starve_drain_addr", rf_waddr, 32'd10);
        chk("starve_drain_data", rf_wdata, 32'd100);
        step();
        chk("hold_drop", 32'(wb_hold), 32'd0);
        chk("ready_back", 32'(md_ready), 32'd1);
        step();
        md_valid = 0;
        idle(6);

        // WAW kill: WB overwrites a queued $7 before it drains.
        chk_addr1 = 5'd7;
        md_valid  = 1;
        md_waddr  = 5'd7;
        md_wdata  = 32'hA;
        step();
        md_valid = 0;
        wb_we    = 1;
        wb_waddr = 5'd7;
        wb_wdata = 32'hB;
        #1;
        chk("kill_pre_hit", 32'(pend_hit1), 32'd1);
        chk("kill_wb_data", rf_wdata, 32'hB);
        step();
        wb_we = 0;
        #1;
        chk("kill_post_hit", 32'(pend_hit1), 32'd0);
        chk("killed_no_write", 32'(rf_we), 32'd0);
        idle(2);

        // Youngest match wins; chk_addr 0 never hits.
        wb_we     = 1;
        wb_waddr  = 5'd20;
        md_valid  = 1;
        md_waddr  = 5'd3;
        md_wdata  = 32'd1;
        step();
        md_wdata  = 32'd2;
        step();
        md_valid  = 0;
        chk_addr1 = 5'd3;
        chk_addr2 = 5'd0;
        #1;
        chk("young_hit1", 32'(pend_hit1), 32'd1);
        chk("young_data1", pend_data1, 32'd2);
        chk("zero_hit2", 32'(pend_hit2), 32'd0);
        step();
        idle(3);

        // Result to $0 is accepted but never written.
        md_valid = 1;
        md_waddr = 5'd0;
        md_wdata = 32'h55;
        step();
        md_valid = 0;
        #1;
        chk("zero_no_write", 32'(rf_we), 32'd0);
        step();

        // Reset with three entries queued flushes them.
        wb_we    = 1;
        wb_waddr = 5'd21;
        md_valid = 1;
        for (int i = 0; i < 3; i++) begin
            md_waddr = 5'(4 + i);
            md_wdata = 32'(40 + i);
            step();
        end
        rst      = 1;
        wb_we    = 0;
        md_waddr = 5'd9;
        repeat (2) begin
            #1;
            chk("rst_no_write", 32'(rf_we), 32'd0);
            step();
        end
        rst = 0;
        md_valid = 0;
        repeat (3) begin
            #1;
            chk("post_rst_no_write", 32'(rf_we), 32'd0);
            step();
        end

        // Randomized traffic with MDU holding its result until accepted.
        last_acc = 1;
        md_valid = 0;
        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0:       busy_pct = 30;
                1:       busy_pct = 90;
                2:       busy_pct = 100;
                default: busy_pct = 50;
            endcase
            if (!md_valid || last_acc) begin
                md_valid = ($urandom_range(0, 1) == 1);
                md_waddr = 5'($urandom_range(0, 7));
                md_wdata = $urandom;
            end
            wb_we     = ($urandom_range(0, 99) < busy_pct);
            wb_waddr  = 5'($urandom_range(0, 7));
            wb_wdata  = $urandom;
            chk_addr1 = 5'($urandom_range(0, 7));
            chk_addr2 = 5'($urandom_range(0, 7));
            step();
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
